// File: rtl/uart_rx_ctrl.sv
// UART receive control: moves bytes from the RX FIFO into RBR and keeps the line status.
// It also runs the error acknowledge handshakes and the receive interrupt; UART_RX_TIMEOUT_EN adds the character timeout.
module uart_rx_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  data_to_reg,
  input  logic        rx_fifo_empty,
  input  logic [4:0]  rx_fifo_cnt,
  output logic        rx_fifo_read,
  input  logic        p_error,
  input  logic        st_error,
  output logic        p_error_ack,
  output logic        st_error_ack,
  input  logic        cpu_rd,
  input  logic        lsr_rd,
  output logic [7:0]  rbr_data,
  output logic [3:0]  lsr,
  input  logic [1:0]  trig_level,
  input  logic        int_en,
  input  logic [15:0] timeout_cycles,
  output logic        rx_int
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SUM_W  = 6;
  localparam int unsigned TMO_W  = 16;

  typedef enum logic [1:0] {ST_EMPTY, ST_FETCH, ST_HOLD} fetch_state_t;
  typedef enum logic {ERR_IDLE, ERR_ACK} err_state_t;

  fetch_state_t      r_state, w_state_nxt;
  err_state_t        r_pe_st, w_pe_st_nxt;
  err_state_t        r_fe_st, w_fe_st_nxt;
  logic              w_pop;
  logic [DATA_W-1:0] r_rbr;
  logic              r_dr, r_pe, r_fe, r_pe_ack, r_fe_ack, r_int;
  logic              w_to;
  logic [SUM_W-1:0]  w_thresh, w_level_sum;
  logic              w_level_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
      r_pe_st <= ERR_IDLE;
      r_fe_st <= ERR_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_pe_st <= w_pe_st_nxt;
      r_fe_st <= w_fe_st_nxt;
    end
  end

  // Fetch FSM: pop one byte, latch it, hold it until the CPU reads RBR
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (!rx_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: w_state_nxt = ST_HOLD;
      ST_HOLD:  if (cpu_rd) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Error handshakes: ack follows the error level, dropping one cycle after it clears
  always_comb begin
    w_pe_st_nxt = r_pe_st;
    w_fe_st_nxt = r_fe_st;
    unique case (r_pe_st)
      ERR_IDLE: if (p_error)  w_pe_st_nxt = ERR_ACK;
      ERR_ACK:  if (!p_error) w_pe_st_nxt = ERR_IDLE;
    endcase
    unique case (r_fe_st)
      ERR_IDLE: if (st_error)  w_fe_st_nxt = ERR_ACK;
      ERR_ACK:  if (!st_error) w_fe_st_nxt = ERR_IDLE;
    endcase
  end

  // Pop is combinational so the byte lands in the FETCH cycle; held off during reset
  assign rx_fifo_read = w_pop & rstn;

  always_comb begin
    unique case (trig_level)
      2'b00:   w_thresh = SUM_W'(1);
      2'b01:   w_thresh = SUM_W'(4);
      2'b10:   w_thresh = SUM_W'(8);
      default: w_thresh = SUM_W'(14);
    endcase
  end

  assign w_level_sum = SUM_W'(rx_fifo_cnt) + SUM_W'(r_dr);
  assign w_level_hit = (w_level_sum >= w_thresh);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rbr    <= '0;
      r_dr     <= 1'b0;
      r_pe     <= 1'b0;
      r_fe     <= 1'b0;
      r_pe_ack <= 1'b0;
      r_fe_ack <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (r_state == ST_FETCH) r_rbr <= data_to_reg;
      r_dr     <= (w_state_nxt == ST_HOLD);
      r_pe_ack <= (w_pe_st_nxt == ERR_ACK);
      r_fe_ack <= (w_fe_st_nxt == ERR_ACK);
      // A live error level outranks a status read
      if (p_error)     r_pe <= 1'b1;
      else if (lsr_rd) r_pe <= 1'b0;
      if (st_error)    r_fe <= 1'b1;
      else if (lsr_rd) r_fe <= 1'b0;
      r_int    <= int_en & (w_level_hit | r_pe | r_fe | w_to);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [CNT_W-1:0] r_cnt_prev;
  logic             r_to;
  logic             w_tmo_run, w_to_set;

  // Count idle cycles while a byte waits in RBR and the FIFO level is static
  assign w_tmo_run = r_dr & ~cpu_rd & (rx_fifo_cnt == r_cnt_prev) & (timeout_cycles != '0);
  assign w_to_set  = w_tmo_run & (r_tmo_cnt < timeout_cycles)
                   & ((r_tmo_cnt + TMO_W'(1)) == timeout_cycles);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tmo_cnt  <= '0;
      r_cnt_prev <= '0;
      r_to       <= 1'b0;
    end else begin
      r_cnt_prev <= rx_fifo_cnt;
      if (!w_tmo_run)                     r_tmo_cnt <= '0;
      else if (r_tmo_cnt < timeout_cycles) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_to_set)             r_to <= 1'b1;
      else if (cpu_rd | lsr_rd) r_to <= 1'b0;
    end
  end

  assign w_to = r_to;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^timeout_cycles;
  assign w_to         = 1'b0;
`endif

  assign rbr_data     = r_rbr;
  assign lsr          = {w_to, r_fe, r_pe, r_dr};
  assign p_error_ack  = r_pe_ack;
  assign st_error_ack = r_fe_ack;
  assign rx_int       = r_int;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a FIFO model feeds bytes, and a negedge monitor checks them.
// The monitor checks RBR at every DR rise and also runs the cycle-stamped expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  data_to_reg = 8'h00;
  logic        rx_fifo_empty = 1'b1;
  logic [4:0]  rx_fifo_cnt = 5'd0;
  logic        rx_fifo_read;
  logic        p_error, st_error, p_error_ack, st_error_ack;
  logic        cpu_rd, lsr_rd;
  logic [7:0]  rbr_data;
  logic [3:0]  lsr;
  logic [1:0]  trig_level;
  logic        int_en;
  logic [15:0] timeout_cycles;
  logic        rx_int;

`ifdef UART_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int S_LSR = 0, S_INT = 1, S_PACK = 2, S_SACK = 3, S_RD = 4,
                 S_POPS = 5, S_RBR = 6, S_SBQ = 7;

  typedef struct {
    int unsigned cyc;
    int          sel;
    int unsigned exp;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [7:0]  exp_data_q[$];
  logic [7:0]  fifo_q[$];
  logic        push_en = 1'b0;
  logic [7:0]  push_data = 8'h00;
  int unsigned pops = 0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_rx_ctrl dut (
    .clk(clk), .rstn(rstn), .data_to_reg(data_to_reg), .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_cnt(rx_fifo_cnt), .rx_fifo_read(rx_fifo_read), .p_error(p_error),
    .st_error(st_error), .p_error_ack(p_error_ack), .st_error_ack(st_error_ack),
    .cpu_rd(cpu_rd), .lsr_rd(lsr_rd), .rbr_data(rbr_data), .lsr(lsr),
    .trig_level(trig_level), .int_en(int_en), .timeout_cycles(timeout_cycles), .rx_int(rx_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: data appears the cycle after a pop strobe
  always @(posedge clk) begin
    if (rx_fifo_read && fifo_q.size() > 0) begin
      data_to_reg <= fifo_q.pop_front();
      pops        <= pops + 1;
    end
    if (push_en && fifo_q.size() < 16) fifo_q.push_back(push_data);
    rx_fifo_cnt   <= 5'(fifo_q.size());
    rx_fifo_empty <= (fifo_q.size() == 0);
  end

  function automatic int unsigned sample(input int sel);
    case (sel)
      S_LSR:   return 32'(lsr);
      S_INT:   return 32'(rx_int);
      S_PACK:  return 32'(p_error_ack);
      S_SACK:  return 32'(st_error_ack);
      S_RD:    return 32'(rx_fifo_read);
      S_POPS:  return pops;
      S_RBR:   return 32'(rbr_data);
      default: return 32'(exp_data_q.size());
    endcase
  endfunction

  chk_t        mon_c;
  int unsigned mon_act;
  logic [7:0]  mon_b;
  logic        dr_q = 1'b0;

  always @(negedge clk) begin
    if (lsr[0] && !dr_q) begin
      n_checks++;
      if (exp_data_q.size() == 0) begin
        n_errors++;
        $display("FAIL rbr_unexpected: DR rose with rbr_data=%02h, no byte expected", rbr_data);
      end else begin
        mon_b = exp_data_q.pop_front();
        if (rbr_data !== mon_b) begin
          n_errors++;
          $display("FAIL rbr_data: got %02h, want %02h (cycle %0d)", rbr_data, mon_b, cyc);
        end
      end
    end
    dr_q = lsr[0];
    if (rx_fifo_read) begin
      n_checks++;
      if (rx_fifo_empty) begin
        n_errors++;
        $display("FAIL pop_while_empty: rx_fifo_read=1 with rx_fifo_empty=1 (cycle %0d)", cyc);
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      mon_c   = chk_q.pop_front();
      mon_act = sample(mon_c.sel);
      n_checks++;
      if (mon_act != mon_c.exp) begin
        n_errors++;
        $display("FAIL %s: got %0h, want %0h (cycle %0d)", mon_c.name, mon_act, mon_c.exp, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int unsigned d, input int sel, input int unsigned exp,
                           input string name);
    chk_t e;
    int   i;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    i = chk_q.size();
    while (i > 0 && chk_q[i-1].cyc > e.cyc) i--;
    chk_q.insert(i, e);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit scored);
    push_en   = 1'b1;
    push_data = b;
    if (scored) exp_data_q.push_back(b);
    step(1);
    push_en = 1'b0;
  endtask

  task automatic cpu_read();
    cpu_rd = 1'b1;
    step(1);
    cpu_rd = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cpu_rd = 1'b0; lsr_rd = 1'b0; p_error = 1'b0; st_error = 1'b0;
    trig_level = 2'b00; int_en = 1'b0; timeout_cycles = 16'd0;
    step(3);
    expect_at(0, S_LSR, 0, "reset_lsr");
    expect_at(0, S_RBR, 0, "reset_rbr");
    expect_at(0, S_INT, 0, "reset_rx_int");
    expect_at(0, S_PACK, 0, "reset_p_ack");
    expect_at(0, S_SACK, 0, "reset_st_ack");
    expect_at(0, S_RD, 0, "reset_pop");
    rstn = 1'b1;
    step(2);

    // Reset while in FETCH: the popped byte never reaches RBR
    push_byte(8'h77, 1'b0);
    step(1);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    expect_at(0, S_RBR, 0, "rst_fetch_rbr");
    expect_at(0, S_LSR, 0, "rst_fetch_lsr");
    expect_at(0, S_POPS, 1, "rst_fetch_pops");
    step(4);
    expect_at(0, S_LSR, 0, "rst_fetch_no_dr");

    // Single byte
    push_byte(8'hA5, 1'b1);
    expect_at(0, S_RD, 1, "single_pop_strobe");
    expect_at(1, S_RD, 0, "single_pop_one_cycle");
    expect_at(1, S_LSR, 0, "single_dr_lat1");
    expect_at(2, S_LSR, 1, "single_dr_lat2");
    expect_at(2, S_POPS, 2, "single_pops");
    step(4);
    cpu_read();
    expect_at(0, S_LSR, 0, "single_dr_clear");
    expect_at(0, S_RBR, 32'hA5, "single_rbr_hold");

    // Back-to-back
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    step(3);
    repeat (3) begin
      cpu_read();
      step(5);
    end
    expect_at(0, S_LSR, 0, "b2b_dr_end");
    expect_at(0, S_POPS, 5, "b2b_pops");
    expect_at(0, S_SBQ, 0, "b2b_all_bytes");
    cpu_read();
    expect_at(0, S_RBR, 32'h33, "cpu_rd_ignored_rbr");
    expect_at(0, S_LSR, 0, "cpu_rd_ignored_lsr");

    // Trigger levels
    int_en = 1'b1;
    trig_level = 2'b01;
    expect_at(1, S_INT, 0, "trig_idle_no_int");
    push_byte(8'hAA, 1'b1);
    push_byte(8'hBB, 1'b1);
    push_byte(8'hCC, 1'b1);
    push_byte(8'hDD, 1'b1);
    step(4);
    expect_at(0, S_INT, 1, "trig4_hit");
    expect_at(0, S_LSR, 1, "trig4_dr");
    trig_level = 2'b10;
    step(1);
    expect_at(0, S_INT, 0, "trig8_miss");
    trig_level = 2'b11;
    expect_at(10, S_INT, 0, "trig14_at13");
    expect_at(11, S_INT, 1, "trig14_at14");
    for (int i = 0; i < 13; i++) push_byte(8'(8'h40 + i), 1'b1);
    step(2);
    expect_at(0, S_INT, 1, "trig14_at17");
    repeat (17) begin
      cpu_read();
      step(5);
    end
    expect_at(0, S_LSR, 0, "drain_dr");
    expect_at(0, S_POPS, 22, "drain_pops");
    expect_at(0, S_SBQ, 0, "drain_all_bytes");
    expect_at(0, S_INT, 0, "drain_no_int");

    // Parity handshake
    p_error = 1'b1;
    expect_at(0, S_PACK, 0, "par_ack_before");
    expect_at(1, S_PACK, 1, "par_ack_rise");
    expect_at(1, S_LSR, 2, "par_pe_set");
    expect_at(1, S_INT, 0, "par_int_lag");
    expect_at(2, S_INT, 1, "par_int");
    expect_at(3, S_SACK, 0, "par_no_st_ack");
    expect_at(6, S_PACK, 1, "par_ack_held");
    expect_at(7, S_PACK, 0, "par_ack_drop");
    expect_at(7, S_LSR, 2, "par_pe_sticky");
    step(6);
    p_error = 1'b0;
    step(2);
    lsr_rd = 1'b1;
    step(1);
    lsr_rd = 1'b0;
    expect_at(0, S_LSR, 0, "par_lsr_rd_clear");
    expect_at(1, S_INT, 0, "par_int_clear");

    // Same-cycle errors
    p_error = 1'b1;
    st_error = 1'b1;
    step(1);
    lsr_rd = 1'b1;
    expect_at(0, S_LSR, 6, "both_flags_set");
    expect_at(0, S_PACK, 1, "both_p_ack");
    expect_at(0, S_SACK, 1, "both_st_ack");
    step(1);
    lsr_rd = 1'b0;
    expect_at(0, S_LSR, 6, "both_set_wins");
    p_error = 1'b0;
    st_error = 1'b0;
    step(3);
    expect_at(0, S_LSR, 6, "both_sticky");
    expect_at(0, S_PACK, 0, "both_p_ack_drop");
    expect_at(0, S_SACK, 0, "both_st_ack_drop");
    lsr_rd = 1'b1;
    step(1);
    lsr_rd = 1'b0;
    expect_at(0, S_LSR, 0, "both_lsr_rd_clear");

    // Character timeout
    int_en = 1'b0;
    timeout_cycles = 16'd10;
    push_byte(8'h5A, 1'b1);
    expect_at(11, S_LSR, 1, "tmo_before_limit");
    expect_at(12, S_LSR, TO_EN ? 32'h9 : 32'h1, "tmo_at_limit");
    step(14);
    cpu_read();
    expect_at(0, S_LSR, 0, "tmo_cpu_rd_clear");
    expect_at(0, S_POPS, 23, "final_pops");
    expect_at(0, S_SBQ, 0, "final_all_bytes");
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
